// File: rtl/instr_fetch.sv
// Instruction fetch unit: streams words from a loadable program memory
// until a zero terminator word or the end of memory is reached.
module instr_fetch #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   output logic [AW-1:0]    pc,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      fetch_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] instr_n;
   logic             valid_n;
   logic [AW-1:0]    pc_n;
   logic [AW:0]      cnt_n;
   logic             wr_en;

   assign word  = mem[pc];
   // Loading is only allowed while parked; a simultaneous start wins.
   assign wr_en = load_en && !start && (state != RUN);

   always_comb begin
      state_n = state;
      instr_n = instr;
      valid_n = instr_valid;
      pc_n    = pc;
      cnt_n   = fetch_count;
      case (state)
         IDLE, DONE: begin
            instr_n = '0;
            valid_n = 1'b0;
            if (start) begin
               state_n = RUN;
               pc_n    = '0;
               cnt_n   = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               if (word == '0) begin
                  instr_n = '0;
                  valid_n = 1'b0;
                  state_n = DONE;
               end else begin
                  instr_n = word;
                  valid_n = 1'b1;
                  pc_n    = pc + AW'(1);
                  cnt_n   = fetch_count + (AW+1)'(1);
                  // Last word of memory is issued and the run ends on the same edge.
                  if (pc == AW'(DEPTH-1)) state_n = DONE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc          <= '0;
         fetch_count <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         instr       <= instr_n;
         instr_valid <= valid_n;
         pc          <= pc_n;
         fetch_count <= cnt_n;
         busy        <= (state_n == RUN);
         done        <= (state_n == DONE);
      end
   end

   // Program memory survives reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[load_addr] <= load_data;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program runs checked against a
// behavioural fetch model every cycle plus hand-computed expectations.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stall = 1'b0, load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic [31:0] instr;
   logic        instr_valid, busy, done;
   logic [3:0]  pc;
   logic [4:0]  fetch_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [0:11] = '{32'h00A08093, 32'h00A10113, 32'h001101B3, 32'h0030A233,
                                32'h00115293, 32'h00211313, 32'h0032F3B3, 32'h0032E433,
                                32'h0032C4B3, 32'h40610533, 32'h004155B3, 32'h00411633};

   instr_fetch #(.WIDTH(32), .DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .instr(instr),
      .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0=idle, 1=running, 2=finished.
   int          ph = 0;
   logic [31:0] mm [16];
   logic [31:0] e_instr = '0;
   logic        e_valid = 1'b0;
   int          e_pc = 0, e_cnt = 0;
   logic        mok = 1'b0;

   initial for (int i = 0; i < 16; i++) mm[i] = '0;

   always @(posedge clk) begin
      if (rst) begin
         ph <= 0; e_instr <= '0; e_valid <= 1'b0; e_pc <= 0; e_cnt <= 0; mok <= 1'b1;
      end else begin
         if (load_en && !start && ph != 1) mm[load_addr] <= load_data;
         if (ph != 1) begin
            e_instr <= '0; e_valid <= 1'b0;
            if (start) begin ph <= 1; e_pc <= 0; e_cnt <= 0; end
         end else if (!stall) begin
            if (mm[e_pc] == 32'h0) begin
               e_instr <= '0; e_valid <= 1'b0; ph <= 2;
            end else begin
               e_instr <= mm[e_pc]; e_valid <= 1'b1;
               e_pc <= (e_pc + 1) % 16; e_cnt <= e_cnt + 1;
               if (e_pc == 15) ph <= 2;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mok) begin
         chk("m_instr", instr, e_instr);
         chk("m_valid", instr_valid, e_valid);
         chk("m_pc", pc, e_pc);
         chk("m_count", fetch_count, e_cnt);
         chk("m_busy", busy, ph == 1);
         chk("m_done", done, ph == 2);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && !done; i++) tick();
      chk("wait_done", done, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_instr", instr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // basic program run
      for (int i = 0; i < 13; i++) begin
         load_en = 1'b1; load_addr = 4'(i);
         load_data = (i < 12) ? prog[i] : 32'h0;
         tick();
      end
      load_en = 1'b0;
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_instr", instr, 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("seq_instr", instr, prog[i]);
         chk("seq_valid", instr_valid, 1);
      end
      tick();
      chk("end_done", done, 1);
      chk("end_count", fetch_count, 12);
      chk("end_pc", pc, 12);
      chk("end_valid", instr_valid, 0);

      // stall in the middle
      pulse_start();
      tick(); tick(); tick();
      chk("pre_stall", instr, 32'h001101B3);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_instr", instr, 32'h001101B3);
         chk("stall_pc", pc, 3);
      end
      stall = 1'b0;
      tick();
      chk("resume", instr, 32'h0030A233);
      wait_done();

      // load attempt during RUN is ignored
      pulse_start();
      load_en = 1'b1; load_addr = 4'd0; load_data = 32'hFFFFFFFF;
      tick(); tick(); tick();
      load_en = 1'b0;
      wait_done();
      pulse_start(); tick();
      chk("no_run_write", instr, 32'h00A08093);
      wait_done();

      // reset aborts a run after the 5th word
      pulse_start();
      for (int i = 0; i < 5; i++) tick();
      chk("fifth", instr, prog[4]);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_instr", instr, 0);
      chk("abort_valid", instr_valid, 0);
      chk("abort_pc", pc, 0);
      chk("abort_count", fetch_count, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      pulse_start(); tick();
      chk("restart", instr, 32'h00A08093);
      wait_done();

      // start together with load_en in IDLE: no write
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 32'hFFFFFFFF;
      tick();
      start = 1'b0; load_en = 1'b0;
      chk("st_ld_busy", busy, 1);
      tick();
      chk("st_ld_nowrite", instr, 32'h00A08093);
      wait_done();

      // full memory, wrap at the end (stall ignored while loading in DONE)
      stall = 1'b1;
      for (int i = 0; i < 16; i++) begin
         load_en = 1'b1; load_addr = 4'(i); load_data = 32'h1000_0000 + 32'(i); tick();
      end
      load_en = 1'b0; stall = 1'b0;
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("full_instr", instr, 32'h1000_0000 + 32'(i));
      end
      chk("full_done", done, 1);
      chk("full_pc", pc, 0);
      chk("full_count", fetch_count, 16);
      tick();
      chk("full_after", instr, 0);
      chk("full_after_v", instr_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
